req_encoder32: RTL and testbench
================================

REQ_ENCODER32 -- requirements
Module: req_encoder32

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port req_i, input, 32 bits: lane request strobes; bit n = lane n; level or pulse.
REQ-004 SHALL have port code_o, output, 5 bits: encoded index of the granted lane (inverse of the 5-to-32 lane decode).
REQ-005 SHALL have port code_valid_o, output, 1 bit: code_o holds a valid grant.
REQ-006 SHALL have port code_ready_i, input, 1 bit: consumer accepts code_o.
REQ-007 SHALL have port pending_o, output, 32 bits: registered pending-request vector.

Function
REQ-008 SHALL OR req_i into pending register each rising edge: pending <= (pending & ~clr) | req_i; set wins over clear for the same bit.
REQ-009 SHALL implement FSM states IDLE, SCAN, PRESENT.
REQ-010 IDLE: pending==0 -> stay IDLE; pending!=0 -> SCAN next edge.
REQ-011 SCAN: one cycle; SHALL register winner index into code_o, go PRESENT; code_valid_o=0 in SCAN.
REQ-012 PRESENT: code_valid_o=1; code_o SHALL stay stable until handshake (code_valid_o & code_ready_i at a rising edge).
REQ-013 On handshake: clr = one-hot(code_o); next state SCAN if (pending & ~clr | req_i) !=0, else IDLE.
REQ-014 Latency: req_i bit sampled at edge E0 -> code_valid_o high after edge E2 (IDLE start); back-to-back grants every 2 cycles with code_ready_i held 1.
REQ-015 Requests arriving during PRESENT SHALL only update pending, never code_o.
REQ-016 Repeated requests on an already-pending lane SHALL merge (no counting, no overflow).
REQ-017 code_ready_i while code_valid_o=0 SHALL be ignored.
REQ-018 Winner index arithmetic 5-bit unsigned, modulo 32 (pointer 31+1 -> 0).

Reset
REQ-019 rst_n low SHALL immediately force: state IDLE, pending 0, code_o 0, code_valid_o 0, pointer 0, pending_o 0.
REQ-020 Reset asserted mid-PRESENT SHALL drop the in-flight grant without handshake; first grant after release follows REQ-014.

Configuration
REQ-021 Macro REQ_ENC_ROUND_ROBIN_EN defined: winner = first pending bit at or above pointer, wrapping 31->0; pointer <= code_o+1 (mod 32) on each handshake.
REQ-022 Macro undefined: fixed priority, winner = lowest-index pending bit; no pointer register present.

Structure
REQ-023 Shared package traffic_pkg SHALL hold NUM_LANES=32, LANE_IDX_W=5, and the FSM state enum.
REQ-024 Combinational sub-module prio_enc32 SHALL produce (index, found) from a 32-bit vector; round-robin built by rotating input by pointer and adding pointer back mod 32.

Verification
REQ-025 Reset, req_i=32'h0000_0001 one cycle, ready=1 -> code_o=0, valid high 2 cycles after sample, pending_o returns 0.
REQ-026 req_i=32'h8000_0001 one cycle, ready=1 -> grants 0 then 31, each 2 cycles apart, then IDLE.
REQ-027 Lane 5 granted, hold ready=0 for 10 cycles while pulsing req_i bit 2 -> code_o stays 5, valid stays 1, pending_o bit 2 set.
REQ-028 Handshake on code 7 with req_i bit 7 high same edge -> pending bit 7 remains set, 7 granted again.
REQ-029 REQ_ENC_ROUND_ROBIN_EN: req_i=32'hFFFF_FFFF held, ready=1 -> codes 0,1,...,31,0 (wrap); without macro -> code 0 repeated.
REQ-030 rst_n low during PRESENT (code 12) -> valid drops asynchronously, pending_o=0, no stale grant after release.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the lane request encoder: lane geometry, FSM states
// and a small one-hot helper.
package traffic_pkg;

  localparam int unsigned NUM_LANES  = 32;
  localparam int unsigned LANE_IDX_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_PRESENT
  } state_t;

  // 5-to-32 lane decode; the encoder's code_o is its inverse.
  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_IDX_W-1:0] idx);
    logic [NUM_LANES-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_enc32.sv
// Combinational 32-bit priority encoder: index of the lowest set bit plus a
// found flag. Index is 0 when nothing is set.
module prio_enc32
  import traffic_pkg::*;
(
  input  logic [31:0] i_vec,
  output logic [4:0]  o_idx,
  output logic        o_found
);

  // Lowest-index set bit wins.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (i_vec[i] && !o_found) begin
        o_idx   = LANE_IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_encoder32.sv
// Lane request encoder: accumulates request strobes into a pending vector and
// presents one granted lane index at a time over a valid/ready handshake.
// Define REQ_ENC_ROUND_ROBIN_EN for round-robin arbitration; otherwise the
// lowest pending lane always wins.
module req_encoder32
  import traffic_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] req_i,
  output logic [4:0]  code_o,
  output logic        code_valid_o,
  input  logic        code_ready_i,
  output logic [31:0] pending_o
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pending;
  logic [31:0] w_pending_nxt;
  logic [31:0] w_clr;
  logic [31:0] w_scan_vec;
  logic [4:0]  r_code;
  logic [4:0]  w_idx;
  logic [4:0]  w_win;
  logic        w_found;
  logic        w_hs;

  assign w_hs          = (r_state == ST_PRESENT) && code_ready_i;
  assign w_clr         = w_hs ? lane_onehot(r_code) : '0;
  assign w_pending_nxt = (r_pending & ~w_clr) | req_i;

`ifdef REQ_ENC_ROUND_ROBIN_EN
  logic [4:0] r_ptr;

  // Rotate pending so the pointer lane lands at bit 0; the encoder result is
  // then an offset from the pointer, added back modulo 32.
  always_comb begin
    w_scan_vec = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      w_scan_vec[i] = r_pending[LANE_IDX_W'(i) + r_ptr];
    end
  end

  assign w_win = w_idx + r_ptr;

  // Pointer moves just past the lane that completed a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_hs) begin
      r_ptr <= r_code + 5'd1;
    end
  end
`else
  assign w_scan_vec = r_pending;
  assign w_win      = w_idx;
`endif

  prio_enc32 u_prio_enc32 (
    .i_vec   (w_scan_vec),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  // Pending accumulation; a new request beats the clear of the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (r_pending != '0) w_state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        w_state_nxt = w_found ? ST_PRESENT : ST_IDLE;
      end
      ST_PRESENT: begin
        if (w_hs) w_state_nxt = (w_pending_nxt != '0) ? ST_SCAN : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Winner is captured only in SCAN, so code_o is frozen while presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code <= '0;
    end else if (r_state == ST_SCAN && w_found) begin
      r_code <= w_win;
    end
  end

  assign code_o       = r_code;
  assign code_valid_o = (r_state == ST_PRESENT);
  assign pending_o    = r_pending;

endmodule

// File: tb/tb_req_encoder32.sv
// Self-checking bench for req_encoder32: directed scenarios plus randomized
// traffic against a behavioural model of the grant protocol.
module tb_req_encoder32;

  logic        clk;
  logic        rst_n;
  logic [31:0] req_i;
  logic [4:0]  code_o;
  logic        code_valid_o;
  logic        code_ready_i;
  logic [31:0] pending_o;

  int n_checks;
  int n_errors;

  // Behavioural model: pending set, presented grant, and whether a winner
  // will be picked at the coming edge.
  logic [31:0] m_pend;
  logic        m_present;
  int          m_code;
  logic        m_sel_due;
  int          m_ptr;

  req_encoder32 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .code_o       (code_o),
    .code_valid_o (code_valid_o),
    .code_ready_i (code_ready_i),
    .pending_o    (pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // First pending lane at or after the start lane, wrapping modulo 32.
  function automatic int winner(input logic [31:0] p, input int start);
    for (int k = 0; k < 32; k++) begin
      int l;
      l = (start + k) % 32;
      if (p[l]) return l;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_pend    = '0;
    m_present = 1'b0;
    m_code    = 0;
    m_sel_due = 1'b0;
    m_ptr     = 0;
  endtask

  task automatic model_edge(input logic [31:0] rq, input logic rd);
    logic        hs;
    logic [31:0] np;
    hs = m_present && rd;
    np = m_pend | rq;
    if (hs && !rq[m_code]) np[m_code] = 1'b0;
    if (m_present) begin
      if (hs) begin
        m_present = 1'b0;
        m_sel_due = (np != 0);
`ifdef REQ_ENC_ROUND_ROBIN_EN
        m_ptr = (m_code + 1) % 32;
`endif
      end
    end else if (m_sel_due) begin
      m_code    = winner(m_pend, m_ptr);
      m_present = 1'b1;
      m_sel_due = 1'b0;
    end else begin
      m_sel_due = (m_pend != 0);
    end
    m_pend = np;
  endtask

  task automatic check_model();
    check_eq("valid", {31'd0, code_valid_o}, {31'd0, m_present});
    check_eq("code", {27'd0, code_o}, m_code);
    check_eq("pending", pending_o, m_pend);
  endtask

  // One clock: drive on the falling edge, model the rising edge, sample after.
  task automatic step(input logic [31:0] rq, input logic rd);
    @(negedge clk);
    req_i        = rq;
    code_ready_i = rd;
    @(posedge clk);
    model_edge(rq, rd);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    req_i        = '0;
    code_ready_i = 1'b0;
    model_reset();
    @(negedge clk);
    check_eq("rst_valid", {31'd0, code_valid_o}, 32'd0);
    check_eq("rst_code", {27'd0, code_o}, 32'd0);
    check_eq("rst_pending", pending_o, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b0;
    req_i        = '0;
    code_ready_i = 1'b0;
    model_reset();

    // Single request on lane 0.
    do_reset();
    step(32'h0000_0001, 1'b1);
    step(32'h0, 1'b1);
    check_eq("r25_valid_e1", {31'd0, code_valid_o}, 32'd0);
    step(32'h0, 1'b1);
    check_eq("r25_valid_e2", {31'd0, code_valid_o}, 32'd1);
    check_eq("r25_code", {27'd0, code_o}, 32'd0);
    step(32'h0, 1'b1);
    check_eq("r25_pend_clear", pending_o, 32'd0);
    check_eq("r25_valid_off", {31'd0, code_valid_o}, 32'd0);

    // Lanes 0 and 31 together.
    do_reset();
    step(32'h8000_0001, 1'b1);
    step(32'h0, 1'b1);
    step(32'h0, 1'b1);
    check_eq("r26_first", {27'd0, code_o}, 32'd0);
    step(32'h0, 1'b1);
    step(32'h0, 1'b1);
    check_eq("r26_second", {27'd0, code_o}, 32'd31);
    check_eq("r26_second_v", {31'd0, code_valid_o}, 32'd1);
    step(32'h0, 1'b1);
    step(32'h0, 1'b1);
    check_eq("r26_idle_v", {31'd0, code_valid_o}, 32'd0);
    check_eq("r26_idle_p", pending_o, 32'd0);

    // Lane 5 held while lane 2 pulses.
    do_reset();
    step(32'h0000_0020, 1'b0);
    step(32'h0, 1'b0);
    step(32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step((i % 2 == 0) ? 32'h0000_0004 : 32'h0, 1'b0);
      check_eq("r27_code", {27'd0, code_o}, 32'd5);
      check_eq("r27_valid", {31'd0, code_valid_o}, 32'd1);
    end
    check_eq("r27_pend2", {31'd0, pending_o[2]}, 32'd1);
    for (int i = 0; i < 4; i++) step(32'h0, 1'b1);

    // Re-request on the lane being acknowledged.
    do_reset();
    step(32'h0000_0080, 1'b0);
    step(32'h0, 1'b0);
    step(32'h0, 1'b0);
    check_eq("r28_code", {27'd0, code_o}, 32'd7);
    step(32'h0000_0080, 1'b1);
    check_eq("r28_pend7", {31'd0, pending_o[7]}, 32'd1);
    step(32'h0, 1'b0);
    check_eq("r28_regrant", {27'd0, code_o}, 32'd7);
    check_eq("r28_regrant_v", {31'd0, code_valid_o}, 32'd1);
    step(32'h0, 1'b1);
    step(32'h0, 1'b1);

    // All lanes requesting continuously.
    do_reset();
    step(32'hFFFF_FFFF, 1'b1);
    step(32'hFFFF_FFFF, 1'b1);
    for (int g = 0; g < 33; g++) begin
      step(32'hFFFF_FFFF, 1'b1);
`ifdef REQ_ENC_ROUND_ROBIN_EN
      check_eq("r29_code", {27'd0, code_o}, g % 32);
`else
      check_eq("r29_code", {27'd0, code_o}, 32'd0);
`endif
      step(32'hFFFF_FFFF, 1'b1);
    end

    // Asynchronous reset while lane 12 is presented.
    do_reset();
    step(32'h0000_1000, 1'b0);
    step(32'h0, 1'b0);
    step(32'h0, 1'b0);
    check_eq("r30_code", {27'd0, code_o}, 32'd12);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("r30_valid_drop", {31'd0, code_valid_o}, 32'd0);
    check_eq("r30_pend_drop", pending_o, 32'd0);
    check_eq("r30_code_drop", {27'd0, code_o}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(32'h0, 1'b1);
    step(32'h0000_0008, 1'b1);
    step(32'h0, 1'b1);
    step(32'h0, 1'b1);
    check_eq("r30_next", {27'd0, code_o}, 32'd3);
    check_eq("r30_next_v", {31'd0, code_valid_o}, 32'd1);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rq;
      logic        rd;
      rq = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom & $urandom) : 32'h0;
      rd = ($urandom_range(0, 3) != 0);
      step(rq, rd);
    end
    for (int i = 0; i < 80; i++) step(32'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
